sht30_responder: RTL and testbench

Synthesizable I2C target that emulates the SHT30 humidity/temperature sensor on the `i2c_scl`/`i2c_sda` bus. It is the counterpart of the SHT30 I2C master: it answers its 7-bit address, accepts 16-bit commands, and returns 6-byte measurement frames with Sensirion CRC-8. It serves as a loop-back target for bench and on-board self-test of the master without a physical sensor.

---
 rtl/sht30_responder_if.sv | 24 ++
 rtl/sht30_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_sht30_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sht30_responder_if.sv
// Host-side view of the SHT30 responder: measurement words in, received command out.
interface sht30_responder_if;
    logic [15:0] temp_data;
    logic [15:0] hum_data;
    logic [15:0] cmd;
    logic        cmd_valid;
    logic        busy;

    modport slave (
        input  temp_data,
        input  hum_data,
        output cmd,
        output cmd_valid,
        output busy
    );

    modport master (
        output temp_data,
        output hum_data,
        input  cmd,
        input  cmd_valid,
        input  busy
    );
endinterface

// File: rtl/sht30_responder.sv
// I2C target emulating an SHT30: ACKs its address, latches 16-bit commands and
// serves {T, CRC(T), H, CRC(H)} read frames. SCL/SDA are oversampled by clk_50M.
module sht30_responder #(
    parameter logic [6:0] ADDR = 7'h44
) (
    input  logic              clk_50M,
    input  logic              rstn,
    input  logic              i2c_scl,
    inout  wire               i2c_sda,
    sht30_responder_if.slave  host
);
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned BYTE_IDX_W = 3;
    localparam int unsigned FRAME_W    = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CMD,
        ST_CMD_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_e;

    // Sensirion CRC-8: poly 0x31, init 0xFF, MSB first, no final XOR
    function automatic logic [7:0] crc8(input logic [15:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;

    state_e                  state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]              shift_q, shift_d;
    logic                    rw_q, rw_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic                    sda_low_q, sda_low_d;
    logic                    ack_on_q, ack_on_d;
    logic [7:0]              cmd_hi_q, cmd_hi_d;
    logic [15:0]             cmd_q, cmd_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    busy_q, busy_d;

    logic scl_c, sda_c, scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [7:0] tx_byte_c;

    // Open-drain: only ever pull low
    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;

    assign host.cmd       = cmd_q;
    assign host.cmd_valid = cmd_valid_q;
    assign host.busy      = busy_q;

    // Two-flop synchronizers plus a delayed copy for edge detection
    always_ff @(posedge clk_50M or negedge rstn) begin
        if (!rstn) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl};
            sda_sync_q <= {sda_sync_q[0], i2c_sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    // START/STOP require SCL high on both samples, so an SDA change coincident
    // with an SCL rise is treated as data
    assign scl_c      = scl_sync_q[1];
    assign sda_c      = sda_sync_q[1];
    assign scl_rise_c = scl_c & ~scl_prev_q;
    assign scl_fall_c = ~scl_c & scl_prev_q;
    assign start_c    = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign stop_c     = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    // Byte currently being transmitted; past the frame end the bus stays released
    always_comb begin
        tx_byte_c = 8'hFF;
        case (byte_idx_q)
            3'd0:    tx_byte_c = frame_q[47:40];
            3'd1:    tx_byte_c = frame_q[39:32];
            3'd2:    tx_byte_c = frame_q[31:24];
            3'd3:    tx_byte_c = frame_q[23:16];
            3'd4:    tx_byte_c = frame_q[15:8];
            3'd5:    tx_byte_c = frame_q[7:0];
            default: tx_byte_c = 8'hFF;
        endcase
    end

    // Protocol FSM: next state and all register updates
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        frame_d     = frame_q;
        sda_low_d   = sda_low_q;
        ack_on_d    = ack_on_q;
        cmd_hi_d    = cmd_hi_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;

        if (start_c) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = '0;
            byte_idx_d = '0;
            sda_low_d  = 1'b0;
            ack_on_d   = 1'b0;
        end else if (stop_c) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
            ack_on_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_low_d = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise_c) begin
                        shift_d = {shift_q[6:0], sda_c};
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            if (shift_q[6:0] == ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = sda_c;
                                if (sda_c) begin
                                    frame_d = {host.temp_data, crc8(host.temp_data),
                                               host.hum_data,  crc8(host.hum_data)};
                                end
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_c) begin
                        if (!ack_on_q) begin
                            sda_low_d = 1'b1;
                            ack_on_d  = 1'b1;
                        end else begin
                            ack_on_d   = 1'b0;
                            byte_idx_d = '0;
                            if (rw_q) begin
                                state_d   = ST_TX;
                                sda_low_d = ~frame_q[47];
                                bit_cnt_d = BIT_CNT_W'(1);
                            end else begin
                                state_d   = ST_CMD;
                                sda_low_d = 1'b0;
                                bit_cnt_d = '0;
                            end
                        end
                    end
                end
                ST_CMD: begin
                    if (scl_rise_c) begin
                        shift_d = {shift_q[6:0], sda_c};
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            if (byte_idx_q < BYTE_IDX_W'(2)) state_d = ST_CMD_ACK;
                            else                             state_d = ST_WAIT_STOP;
                        end else begin
                            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
                        end
                    end
                end
                ST_CMD_ACK: begin
                    if (scl_fall_c) begin
                        if (!ack_on_q) begin
                            sda_low_d = 1'b1;
                            ack_on_d  = 1'b1;
                        end else begin
                            ack_on_d  = 1'b0;
                            sda_low_d = 1'b0;
                            // First byte is held aside so a truncated write leaves cmd intact
                            if (byte_idx_q == BYTE_IDX_W'(0)) begin
                                cmd_hi_d = shift_q;
                            end else begin
                                cmd_d       = {cmd_hi_q, shift_q};
                                cmd_valid_d = 1'b1;
                            end
                            byte_idx_d = BYTE_IDX_W'(byte_idx_q + 1'b1);
                            state_d    = ST_CMD;
                        end
                    end
                end
                ST_TX: begin
                    if (scl_fall_c) begin
                        if (bit_cnt_q == BIT_CNT_W'(8)) begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            sda_low_d = ~tx_byte_c[3'(4'd7 - bit_cnt_q)];
                            bit_cnt_d = BIT_CNT_W'(bit_cnt_q + 1'b1);
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise_c) begin
                        if (!sda_c) begin
                            state_d   = ST_TX;
                            bit_cnt_d = '0;
                            if (byte_idx_q != BYTE_IDX_W'(7)) begin
                                byte_idx_d = BYTE_IDX_W'(byte_idx_q + 1'b1);
                            end
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    sda_low_d = 1'b0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset releases the bus immediately
    always_ff @(posedge clk_50M or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            frame_q     <= '0;
            sda_low_q   <= 1'b0;
            ack_on_q    <= 1'b0;
            cmd_hi_q    <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            frame_q     <= frame_d;
            sda_low_q   <= sda_low_d;
            ack_on_q    <= ack_on_d;
            cmd_hi_q    <= cmd_hi_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_sht30_responder.sv
// Directed bench: bit-banged I2C master against the SHT30 responder.
module tb_sht30_responder;
    localparam int unsigned Q = 10;   // quarter SCL period in clk cycles

    logic clk_50M = 1'b0;
    logic rstn;
    logic i2c_scl;
    logic sda_m;
    wire  i2c_sda;

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int tgt_low_cnt = 0;

    always #10 clk_50M = ~clk_50M;

    assign i2c_sda = sda_m ? 1'bz : 1'b0;
    pullup (i2c_sda);

    sht30_responder_if host ();

    sht30_responder #(.ADDR(7'h44)) dut (
        .clk_50M (clk_50M),
        .rstn    (rstn),
        .i2c_scl (i2c_scl),
        .i2c_sda (i2c_sda),
        .host    (host)
    );

    // Count cmd_valid pulses and cycles where the target pulls SDA low
    always @(posedge clk_50M) begin
        if (host.cmd_valid) valid_cnt++;
        if (!i2c_sda && sda_m) tgt_low_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        tick(Q); i2c_scl = 1'b1;
        tick(2*Q); i2c_scl = 1'b0;
        tick(Q);
    endtask

    task automatic get_bit(output logic v);
        sda_m = 1'b1;
        tick(Q); i2c_scl = 1'b1;
        tick(Q); v = i2c_sda;
        tick(Q); i2c_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        tick(Q); i2c_scl = 1'b1;
        tick(Q); sda_m = 1'b0;
        tick(Q); i2c_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(Q); i2c_scl = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        get_bit(nack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic v;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(v);
            b = {b[6:0], v};
        end
        send_bit(nack);
    endtask

    logic       ack;
    logic [7:0] rd;
    logic [7:0] exp_frame [7];
    int         v0, l0;

    initial begin
        rstn = 1'b0;
        i2c_scl = 1'b1;
        sda_m = 1'b1;
        host.temp_data = 16'hBEEF;
        host.hum_data  = 16'h1234;
        tick(5);
        check("rst_busy", 32'(host.busy), 32'h0);
        check("rst_cmd", 32'(host.cmd), 32'h0);
        check("rst_valid", 32'(host.cmd_valid), 32'h0);
        check("rst_sda", 32'(i2c_sda), 32'h1);
        rstn = 1'b1;
        tick(10);

        // Write command 0x2C06
        v0 = valid_cnt;
        i2c_start();
        write_byte(8'h88, ack); check("wr_addr_ack", 32'(ack), 32'h0);
        check("wr_busy", 32'(host.busy), 32'h1);
        write_byte(8'h2C, ack); check("wr_b0_ack", 32'(ack), 32'h0);
        write_byte(8'h06, ack); check("wr_b1_ack", 32'(ack), 32'h0);
        i2c_stop();
        tick(10);
        check("wr_cmd", 32'(host.cmd), 32'h2C06);
        check("wr_valid_pulses", 32'(valid_cnt - v0), 32'h1);
        check("wr_busy_after_stop", 32'(host.busy), 32'h0);

        // Read 6 bytes, NACK the last
        exp_frame = '{8'hBE, 8'hEF, 8'h92, 8'h12, 8'h34, 8'h37, 8'hFF};
        i2c_start();
        write_byte(8'h89, ack); check("rd_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 6; i++) begin
            read_byte(i == 5, rd);
            check($sformatf("rd_byte%0d", i), 32'(rd), 32'(exp_frame[i]));
        end
        tick(2);
        check("rd_sda_released", 32'(i2c_sda), 32'h1);
        i2c_stop();
        tick(10);
        check("rd_busy_after_stop", 32'(host.busy), 32'h0);

        // Wrong address: no response at all
        l0 = tgt_low_cnt;
        i2c_start();
        write_byte(8'h90, ack); check("mis_addr_nack", 32'(ack), 32'h1);
        check("mis_busy", 32'(host.busy), 32'h0);
        write_byte(8'h2C, ack); check("mis_data_nack", 32'(ack), 32'h1);
        check("mis_busy2", 32'(host.busy), 32'h0);
        i2c_stop();
        tick(10);
        check("mis_never_low", 32'(tgt_low_cnt - l0), 32'h0);

        // Truncated write then repeated START into a read
        v0 = valid_cnt;
        host.temp_data = 16'h1234;
        host.hum_data  = 16'hBEEF;
        exp_frame = '{8'h12, 8'h34, 8'h37, 8'hBE, 8'hEF, 8'h92, 8'hFF};
        i2c_start();
        write_byte(8'h88, ack); check("rs_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h2C, ack); check("rs_b0_ack", 32'(ack), 32'h0);
        i2c_start();
        write_byte(8'h89, ack); check("rs_raddr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 6; i++) begin
            read_byte(i == 5, rd);
            check($sformatf("rs_byte%0d", i), 32'(rd), 32'(exp_frame[i]));
        end
        i2c_stop();
        tick(10);
        check("rs_cmd_kept", 32'(host.cmd), 32'h2C06);
        check("rs_no_valid", 32'(valid_cnt - v0), 32'h0);

        // Reset while the target holds the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h88 >> i));
        sda_m = 1'b1;
        tick(Q); i2c_scl = 1'b1;
        tick(Q);
        check("rst_mid_ack_low", 32'(i2c_sda), 32'h0);
        rstn = 1'b0;
        #1;
        check("rst_mid_sda_z", 32'(i2c_sda), 32'h1);
        check("rst_mid_cmd", 32'(host.cmd), 32'h0);
        check("rst_mid_busy", 32'(host.busy), 32'h0);
        check("rst_mid_valid", 32'(host.cmd_valid), 32'h0);
        tick(Q); i2c_scl = 1'b0;
        tick(Q);
        rstn = 1'b1;
        tick(5);
        write_byte(8'h88, ack); check("rst_post_ignore", 32'(ack), 32'h1);
        check("rst_post_busy", 32'(host.busy), 32'h0);
        i2c_stop();
        tick(10);
        v0 = valid_cnt;
        i2c_start();
        write_byte(8'h88, ack); check("rst_wr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h24, ack); check("rst_wr_b0_ack", 32'(ack), 32'h0);
        write_byte(8'h00, ack); check("rst_wr_b1_ack", 32'(ack), 32'h0);
        i2c_stop();
        tick(10);
        check("rst_wr_cmd", 32'(host.cmd), 32'h2400);
        check("rst_wr_valid", 32'(valid_cnt - v0), 32'h1);

        // Read past the frame end, then recover with repeated START and STOP
        host.temp_data = 16'hBEEF;
        host.hum_data  = 16'h1234;
        exp_frame = '{8'hBE, 8'hEF, 8'h92, 8'h12, 8'h34, 8'h37, 8'hFF};
        i2c_start();
        write_byte(8'h89, ack); check("long_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 7; i++) begin
            read_byte(1'b0, rd);
            check($sformatf("long_byte%0d", i), 32'(rd), 32'(exp_frame[i]));
        end
        v0 = valid_cnt;
        i2c_start();
        write_byte(8'h88, ack); check("long_rs_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h30, ack); check("long_rs_b0_ack", 32'(ack), 32'h0);
        write_byte(8'hA2, ack); check("long_rs_b1_ack", 32'(ack), 32'h0);
        i2c_stop();
        tick(10);
        check("long_cmd", 32'(host.cmd), 32'h30A2);
        check("long_valid", 32'(valid_cnt - v0), 32'h1);
        check("long_busy", 32'(host.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
